// File: rtl/comparator_pkg.sv
// Shared types for the serial comparator: FSM states, result encodings and
// the counter-width helper.
package comparator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] RES_UNDEC = 2'd0;
   localparam logic [1:0] RES_LT    = 2'd1;
   localparam logic [1:0] RES_EQ    = 2'd2;
   localparam logic [1:0] RES_GT    = 2'd3;

   // Counter width: ceil(log2(w)), but never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/comparator_1bit.sv
// Combinational magnitude compare of one a/b bit pair.
// Zero latency, no flow control.
module comparator_1bit (
   input  logic a_bit,
   input  logic b_bit,
   output logic lt,
   output logic eq,
   output logic gt
);

   assign lt = ~a_bit &  b_bit;
   assign gt =  a_bit & ~b_bit;
   assign eq = ~(a_bit ^ b_bit);

endmodule

// File: rtl/serial_comparator.sv
// MSB-first serial compare of two WIDTH-bit operands; done pulses WIDTH+1 cycles
// after start when bit_valid stays high, and bit_valid low simply stalls SHIFT.
module serial_comparator
   import comparator_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic lt,
   output logic eq,
   output logic gt
);

   localparam int CW = cnt_width(WIDTH);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    decision;
   logic          c_lt;
   logic          c_eq;
   logic          c_gt;
   logic [1:0]    bit_res;
   logic [1:0]    final_res;

   comparator_1bit u_cell (
      .a_bit (a_bit),
      .b_bit (b_bit),
      .lt    (c_lt),
      .eq    (c_eq),
      .gt    (c_gt)
   );

   // The last consumed pair can still decide when all earlier pairs were equal.
   always_comb begin
      bit_res   = c_eq ? RES_EQ : (c_gt ? RES_GT : RES_LT);
      final_res = (decision != RES_UNDEC) ? decision : bit_res;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         decision <= RES_UNDEC;
         busy     <= 1'b0;
         done     <= 1'b0;
         lt       <= 1'b0;
         eq       <= 1'b0;
         gt       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= SHIFT;
                  cnt      <= CW'(WIDTH - 1);
                  decision <= RES_UNDEC;
                  busy     <= 1'b1;
                  lt       <= 1'b0;
                  eq       <= 1'b0;
                  gt       <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (bit_valid) begin
                  if (decision == RES_UNDEC && !c_eq)
                     decision <= bit_res;
                  if (cnt == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     lt    <= (final_res == RES_LT);
                     eq    <= (final_res == RES_EQ);
                     gt    <= (final_res == RES_GT);
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (WIDTH=3) with hand-computed results.
module tb_serial_comparator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic bit_valid = 1'b0;
   logic a_bit = 1'b0;
   logic b_bit = 1'b0;
   logic busy, done, lt, eq, gt;
   logic [2:0] res;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int t0    = 0;

   localparam logic [2:0] R_LT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_GT = 3'b001;
   localparam logic [2:0] R_NONE = 3'b000;

   serial_comparator #(.WIDTH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bit_valid (bit_valid),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .busy      (busy),
      .done      (done),
      .lt        (lt),
      .eq        (eq),
      .gt        (gt)
   );

   assign res = {lt, eq, gt};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Raise start for one cycle; the accepting edge takes us into SHIFT.
   task automatic start_op(input string tag);
      start     = 1'b1;
      bit_valid = 1'b0;
      t0        = cyc;
      step();
      start = 1'b0;
      chk({tag, " busy after start"}, 32'(busy), 1);
      chk({tag, " done after start"}, 32'(done), 0);
      chk({tag, " res cleared"}, 32'(res), 32'(R_NONE));
   endtask

   // Feed three MSB-first bit pairs, optional stall after the first, optional
   // stray start with the middle pair; checks result and latency at DONE.
   task automatic feed(input string tag, input logic [2:0] a, input logic [2:0] b,
                       input int gap_len, input bit mid_start, input logic [2:0] exp);
      for (int i = 2; i >= 0; i--) begin
         a_bit     = a[i];
         b_bit     = b[i];
         bit_valid = 1'b1;
         start     = mid_start && (i == 1);
         step();
         bit_valid = 1'b0;
         start     = 1'b0;
         if (i == 2) begin
            for (int g = 0; g < gap_len; g++) begin
               a_bit = ~a_bit;
               b_bit = ~b_bit;
               chk({tag, " busy in stall"}, 32'(busy), 1);
               step();
            end
         end
         if (i > 0) begin
            chk({tag, " busy mid"}, 32'(busy), 1);
            chk({tag, " no early done"}, 32'(done), 0);
         end
      end
      chk({tag, " done"}, 32'(done), 1);
      chk({tag, " busy in done"}, 32'(busy), 0);
      chk({tag, " result"}, 32'(res), 32'(exp));
      chk({tag, " latency"}, 32'(cyc - t0), 32'(4 + gap_len));
   endtask

   task automatic after_done(input string tag, input logic [2:0] exp);
      step();
      chk({tag, " done cleared"}, 32'(done), 0);
      chk({tag, " idle busy"}, 32'(busy), 0);
      chk({tag, " result held"}, 32'(res), 32'(exp));
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset res", 32'(res), 32'(R_NONE));
      rst = 1'b0;
      step();
      chk("idle res", 32'(res), 32'(R_NONE));

      start_op("eq100");
      feed("eq100", 3'b100, 3'b100, 0, 1'b0, R_EQ);
      after_done("eq100", R_EQ);

      start_op("lt000");
      feed("lt000", 3'b000, 3'b001, 0, 1'b0, R_LT);
      after_done("lt000", R_LT);

      start_op("gt100");
      feed("gt100", 3'b100, 3'b011, 0, 1'b0, R_GT);
      after_done("gt100", R_GT);

      start_op("stall");
      feed("stall", 3'b001, 3'b101, 2, 1'b0, R_LT);
      after_done("stall", R_LT);

      start_op("midstart");
      feed("midstart", 3'b110, 3'b101, 0, 1'b1, R_GT);
      after_done("midstart", R_GT);
      step();
      chk("midstart no second done", 32'(done), 0);

      // Abandon a comparison after two pairs.
      start_op("abort");
      a_bit = 1'b1; b_bit = 1'b0; bit_valid = 1'b1;
      step();
      step();
      rst = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; start = 1'b0; bit_valid = 1'b1;
      chk("abort busy", 32'(busy), 0);
      chk("abort done", 32'(done), 0);
      chk("abort res", 32'(res), 32'(R_NONE));
      for (int k = 0; k < 4; k++) begin
         step();
         chk("abort no done", 32'(done), 0);
         chk("abort stays idle", 32'(busy), 0);
      end
      bit_valid = 1'b0;
      start_op("eq010");
      feed("eq010", 3'b010, 3'b010, 0, 1'b0, R_EQ);

      // Back-to-back: start raised in the DONE cycle.
      start_op("b2b_from_done");
      feed("b2b_lt", 3'b001, 3'b011, 0, 1'b0, R_LT);
      start_op("b2b_again");
      feed("b2b_gt", 3'b011, 3'b010, 0, 1'b0, R_GT);
      after_done("b2b_gt", R_GT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 3: operand width in bits (WIDTH >= 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 start  input  1  request to begin a new comparison; honoured only in IDLE or DONE.
REQ-005 bit_valid  input  1  a_bit/b_bit carry an operand bit this cycle.
REQ-006 a_bit  input  1  operand A bit, MSB first.
REQ-007 b_bit  input  1  operand B bit, MSB first.
REQ-008 busy  output  1  high while in SHIFT.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 lt  output  1  A < B.
REQ-011 eq  output  1  A == B.
REQ-012 gt  output  1  A > B.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 -> SHIFT; the bit counter loads WIDTH-1 and the decision register clears to "undecided"; otherwise remain in IDLE.
REQ-015 No operand bit is consumed in the cycle in which start is accepted.
REQ-016 SHIFT: each cycle with bit_valid=1 consumes one bit pair; cycles with bit_valid=0 consume nothing, and all state holds.
REQ-017 The decision is set at the first consumed pair with a_bit != b_bit: a_bit=1 gives gt, a_bit=0 gives lt.
REQ-018 Bits consumed after the decision is set do not change it.
REQ-019 When the WIDTH-th bit pair is consumed, the FSM moves SHIFT -> DONE.
REQ-020 If the decision is still undecided at that point, the result is eq.
REQ-021 start asserted in SHIFT is ignored.
REQ-022 DONE lasts exactly one cycle, with done=1 and busy=0.
REQ-023 DONE with start=1 moves to SHIFT (back-to-back operation); otherwise DONE moves to IDLE.
REQ-024 Latency: start accepted at cycle T with bit_valid held high gives bits at T+1..T+WIDTH and done at T+WIDTH+1.
REQ-025 lt/eq/gt are registered and become valid in the DONE cycle.
REQ-026 lt/eq/gt then hold until the next accepted start.
REQ-027 lt/eq/gt are all 0 from the cycle after an accepted start until the next DONE.
REQ-028 Whenever the result is valid, exactly one of lt/eq/gt is 1.
REQ-029 The bit counter is ceil(log2(WIDTH)) bits wide (minimum 1) and never wraps.
REQ-030 When WIDTH=1, SHIFT consumes exactly one pair.

Reset
REQ-031 rst=1 at a clock edge forces IDLE, counter=0, decision undecided, and busy=done=lt=eq=gt=0, regardless of state.
REQ-032 Reset mid-SHIFT abandons the comparison; no done pulse follows.
REQ-033 rst has priority over start and bit_valid in the same cycle.

Structure
REQ-034 Shared package comparator_pkg holds the FSM state typedef (IDLE/SHIFT/DONE) and the result encoding constants (RES_LT, RES_EQ, RES_GT, RES_UNDEC).
REQ-035 One sub-module, comparator_1bit, is a combinational single-bit cell producing lt/eq/gt for one a_bit/b_bit pair.
REQ-036 serial_comparator instantiates comparator_1bit once and latches the first non-eq result.

Verification
REQ-037 WIDTH=3, A=100, B=100, bit_valid always high: done at T+4, eq=1, lt=gt=0.
REQ-038 A=000, B=001: lt=1 at done; A=100, B=011: gt=1 at done, with the decision fixed after the first bit pair.
REQ-039 A=001, B=101 with bit_valid low for 2 cycles between bits 1 and 2: lt=1, done at T+6, busy high throughout SHIFT.
REQ-040 start pulsed again mid-SHIFT: ignored; the single done pulse carries the result of the original operands.
REQ-041 rst asserted after 2 bits: next cycle IDLE with all outputs 0; a new start with A=010, B=010 gives eq=1.
REQ-042 Back-to-back: start held in the DONE cycle gives SHIFT next; lt/eq/gt clear; the second result is correct.
